// File: rtl/refill_victim_pkg.sv
// ============================================================================
// Module : refill_victim_pkg
// Brief  : Shared types and constants for the refill victim-way selector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package refill_victim_pkg;

    localparam int MAX_WAYS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/refill_victim_sel_way_rr_pick.sv
// ============================================================================
// Module : way_rr_pick
// Brief  : Combinational rotating first-set finder: first mask bit at index
//          >= start, wrapping modulo NR_WAYS.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module way_rr_pick
    import refill_victim_pkg::*;
#(
    parameter int NR_WAYS = 8,
    parameter int WAY_W   = $clog2(NR_WAYS)
) (
    input  logic [NR_WAYS-1:0] mask,
    input  logic [WAY_W-1:0]   start,
    output logic [NR_WAYS-1:0] oh,
    output logic [WAY_W-1:0]   bin,
    output logic               found
);

    logic [WAY_W-1:0] w_idx;

    // NR_WAYS is a power of two, so the WAY_W-bit sum wraps naturally.
    always_comb begin
        oh    = '0;
        bin   = '0;
        found = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NR_WAYS; i++) begin
            w_idx = start + WAY_W'(i);
            if (!found && mask[w_idx]) begin
                found     = 1'b1;
                oh[w_idx] = 1'b1;
                bin       = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/refill_victim_sel.sv
// ============================================================================
// Module : refill_victim_sel
// Brief  : Victim-way selector for cache refills: lowest invalid unlocked way
//          first, else LFSR-seeded rotation past locked ways.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module refill_victim_sel
    import refill_victim_pkg::*;
#(
    parameter  int NR_WAYS = 8,
    localparam int WAY_W   = $clog2(NR_WAYS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [NR_WAYS-1:0] way_valid_i,
    input  logic [NR_WAYS-1:0] way_lock_i,
    input  logic [2:0]         lfsr_bin_i,
    output logic               lfsr_en_o,
    output logic               victim_valid_o,
    input  logic               victim_ready_i,
    output logic [NR_WAYS-1:0] victim_way_oh_o,
    output logic [WAY_W-1:0]   victim_way_bin_o,
    output logic               victim_evict_o,
    output logic               victim_none_o
);

    state_t r_state;
    state_t w_state_next;

    logic [NR_WAYS-1:0] r_valid_q;
    logic [NR_WAYS-1:0] r_lock_q;
    logic [NR_WAYS-1:0] r_oh;
    logic [WAY_W-1:0]   r_bin;
    logic               r_evict;
    logic               r_none;

    logic [NR_WAYS-1:0] w_cand;
    logic [NR_WAYS-1:0] w_inv_oh;
    logic [WAY_W-1:0]   w_inv_bin;
    logic               w_inv_found;
    logic [NR_WAYS-1:0] w_rnd_oh;
    logic [WAY_W-1:0]   w_rnd_bin;
    logic               w_rnd_found;

    logic [NR_WAYS-1:0] w_sel_oh;
    logic [WAY_W-1:0]   w_sel_bin;
    logic               w_sel_evict;
    logic               w_sel_none;
    logic               w_use_rnd;

    assign w_cand = ~r_lock_q;

    way_rr_pick #(.NR_WAYS(NR_WAYS), .WAY_W(WAY_W)) u_pick_invalid (
        .mask  (w_cand & ~r_valid_q),
        .start ('0),
        .oh    (w_inv_oh),
        .bin   (w_inv_bin),
        .found (w_inv_found)
    );

    way_rr_pick #(.NR_WAYS(NR_WAYS), .WAY_W(WAY_W)) u_pick_random (
        .mask  (w_cand),
        .start (lfsr_bin_i[WAY_W-1:0]),
        .oh    (w_rnd_oh),
        .bin   (w_rnd_bin),
        .found (w_rnd_found)
    );

    // Invalid ways win over the random path; an empty candidate set yields "none".
    always_comb begin
        w_sel_oh    = '0;
        w_sel_bin   = '0;
        w_sel_evict = 1'b0;
        w_sel_none  = 1'b0;
        w_use_rnd   = 1'b0;
        if (w_inv_found) begin
            w_sel_oh  = w_inv_oh;
            w_sel_bin = w_inv_bin;
        end else if (!w_rnd_found) begin
            w_sel_none = 1'b1;
        end else begin
            w_sel_oh    = w_rnd_oh;
            w_sel_bin   = w_rnd_bin;
            w_sel_evict = 1'b1;
            w_use_rnd   = 1'b1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        req_ready_o    = 1'b0;
        victim_valid_o = 1'b0;
        lfsr_en_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                lfsr_en_o    = w_use_rnd;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                victim_valid_o = 1'b1;
                if (victim_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_valid_q <= '0;
            r_lock_q  <= '0;
            r_oh      <= '0;
            r_bin     <= '0;
            r_evict   <= 1'b0;
            r_none    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && req_valid_i) begin
                r_valid_q <= way_valid_i;
                r_lock_q  <= way_lock_i;
            end
            if (r_state == ST_SELECT) begin
                r_oh    <= w_sel_oh;
                r_bin   <= w_sel_bin;
                r_evict <= w_sel_evict;
                r_none  <= w_sel_none;
            end
        end
    end

    assign victim_way_oh_o  = r_oh;
    assign victim_way_bin_o = r_bin;
    assign victim_evict_o   = r_evict;
    assign victim_none_o    = r_none;

endmodule

`default_nettype wire

// File: tb/tb_refill_victim_sel.sv
// ============================================================================
// Module : tb_refill_victim_sel
// Brief  : Self-checking bench for refill_victim_sel (vector table + random).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_refill_victim_sel;

    typedef struct {
        logic [7:0] valid;
        logic [7:0] lock;
        logic [2:0] lfsr;
        logic [7:0] oh;
        logic [2:0] bin;
        logic       evict;
        logic       none;
        logic       en;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] way_valid;
    logic [7:0] way_lock;
    logic [2:0] lfsr_bin;
    logic       lfsr_en;
    logic       victim_valid;
    logic       victim_ready;
    logic [7:0] victim_oh;
    logic [2:0] victim_bin;
    logic       victim_evict;
    logic       victim_none;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    refill_victim_sel #(.NR_WAYS(8)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .way_valid_i      (way_valid),
        .way_lock_i       (way_lock),
        .lfsr_bin_i       (lfsr_bin),
        .lfsr_en_o        (lfsr_en),
        .victim_valid_o   (victim_valid),
        .victim_ready_i   (victim_ready),
        .victim_way_oh_o  (victim_oh),
        .victim_way_bin_o (victim_bin),
        .victim_evict_o   (victim_evict),
        .victim_none_o    (victim_none)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: spec rules expressed with plain integer arithmetic.
    function automatic vec_t model(input logic [7:0] v, input logic [7:0] l, input logic [2:0] lf);
        vec_t r;
        int   first_inv;
        r.valid = v; r.lock = l; r.lfsr = lf;
        r.oh = '0; r.bin = '0; r.evict = 1'b0; r.none = 1'b0; r.en = 1'b0;
        first_inv = -1;
        for (int i = 0; i < 8; i++)
            if (first_inv < 0 && !l[i] && !v[i]) first_inv = i;
        if (first_inv >= 0) begin
            r.oh  = 8'(1) << first_inv;
            r.bin = 3'(first_inv);
        end else if (l == 8'hFF) begin
            r.none = 1'b1;
        end else begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (int'(lf) + k) % 8;
                if (r.oh == 0 && !l[idx]) begin
                    r.oh  = 8'(1) << idx;
                    r.bin = 3'(idx);
                end
            end
            r.evict = 1'b1;
            r.en    = 1'b1;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] v, input logic [7:0] l, input logic [2:0] lf,
                                input logic [7:0] oh, input logic [2:0] b,
                                input logic ev, input logic no, input logic en);
        vec_t r;
        r.valid = v; r.lock = l; r.lfsr = lf; r.oh = oh; r.bin = b;
        r.evict = ev; r.none = no; r.en = en;
        return r;
    endfunction

    task automatic inv();
        logic [2:0] eb;
        eb = '0;
        for (int i = 0; i < 8; i++) if (victim_oh[i]) eb = 3'(i);
        chk("oh_onehot0", 32'($onehot0(victim_oh)), 32'd1);
        chk("bin_vs_oh", victim_bin, eb);
        chk("lfsr_en_outside_select", lfsr_en && (req_ready || victim_valid), 0);
    endtask

    task automatic half();
        @(negedge clk);
        inv();
    endtask

    task automatic edge_t();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input vec_t t);
        chk({tag, "_valid"}, victim_valid, 1);
        chk({tag, "_oh"},    victim_oh,    t.oh);
        chk({tag, "_bin"},   victim_bin,   t.bin);
        chk({tag, "_evict"}, victim_evict, t.evict);
        chk({tag, "_none"},  victim_none,  t.none);
        chk({tag, "_ready"}, req_ready,    0);
        chk({tag, "_lfsr_en"}, lfsr_en,    0);
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_req(input vec_t t, input int hold, input string tag);
        req_valid = 1'b1; way_valid = t.valid; way_lock = t.lock; lfsr_bin = t.lfsr;
        victim_ready = 1'b0;
        half();
        chk({tag, "_accept_ready"}, req_ready, 1);
        edge_t();
        req_valid = 1'b0; way_valid = 8'($urandom); way_lock = 8'($urandom);
        half();
        chk({tag, "_sel_valid"},   victim_valid, 0);
        chk({tag, "_sel_ready"},   req_ready,    0);
        chk({tag, "_sel_lfsr_en"}, lfsr_en,      t.en);
        edge_t();
        lfsr_bin = 3'($urandom);
        half();
        chk_result({tag, "_resp"}, t);
        for (int h = 0; h < hold; h++) begin
            edge_t();
            half();
            chk_result({tag, "_hold"}, t);
        end
        victim_ready = 1'b1;
        edge_t();
        victim_ready = 1'b0;
        half();
        chk({tag, "_idle_ready"}, req_ready,    1);
        chk({tag, "_idle_valid"}, victim_valid, 0);
        edge_t();
    endtask

    vec_t tbl[8];
    vec_t t;

    initial begin
        tbl[0] = mk(8'hFF, 8'h00, 3'd5, 8'h20, 3'd5, 1'b1, 1'b0, 1'b1);
        tbl[1] = mk(8'hF5, 8'h00, 3'd0, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
        tbl[2] = mk(8'hFF, 8'h60, 3'd5, 8'h80, 3'd7, 1'b1, 1'b0, 1'b1);
        tbl[3] = mk(8'hFF, 8'h80, 3'd7, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);
        tbl[4] = mk(8'hFE, 8'h01, 3'd0, 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
        tbl[5] = mk(8'hFF, 8'hFF, 3'd3, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        tbl[6] = mk(8'h00, 8'h0F, 3'd2, 8'h10, 3'd4, 1'b0, 1'b0, 1'b0);
        tbl[7] = mk(8'h7F, 8'h00, 3'd1, 8'h80, 3'd7, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; req_valid = 1'b0; way_valid = '0; way_lock = '0;
        lfsr_bin = '0; victim_ready = 1'b0;
        half();
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", victim_valid, 0);
        chk("rst_lfsr_en", lfsr_en, 0);
        chk("rst_oh", victim_oh, 0);
        chk("rst_bin", victim_bin, 0);
        chk("rst_evict", victim_evict, 0);
        chk("rst_none", victim_none, 0);
        edge_t();
        rst_n = 1'b1;
        edge_t();

        for (int i = 0; i < 8; i++) run_req(tbl[i], 0, $sformatf("tbl%0d", i));

        // Back-pressure: result held stable for 4 cycles.
        run_req(tbl[2], 4, "hold4");

        for (int n = 0; n < 40; n++) begin
            logic [7:0] v, l;
            v = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            l = ($urandom_range(0, 3) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 9) == 0) l = 8'hFF;
            t = model(v, l, 3'($urandom));
            run_req(t, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        // Reset while the result is being presented.
        req_valid = 1'b1; way_valid = 8'hFF; way_lock = 8'h00; lfsr_bin = 3'd5;
        half(); edge_t();
        req_valid = 1'b0;
        half(); edge_t();
        half();
        chk("rresp_pre_valid", victim_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rresp_valid", victim_valid, 0);
        chk("rresp_ready", req_ready, 1);
        chk("rresp_oh", victim_oh, 0);
        chk("rresp_evict", victim_evict, 0);
        edge_t();
        rst_n = 1'b1;
        half();
        chk("rresp_after_ready", req_ready, 1);
        edge_t();

        // Reset while selecting on the random path: no LFSR advance is sampled.
        req_valid = 1'b1; way_valid = 8'hFF; way_lock = 8'h00; lfsr_bin = 3'd5;
        half(); edge_t();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rsel_lfsr_en", lfsr_en, 0);
        for (int c = 0; c < 2; c++) begin
            half();
            chk("rsel_in_rst_en", lfsr_en, 0);
            edge_t();
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            half();
            chk("rsel_after_en", lfsr_en, 0);
            chk("rsel_after_valid", victim_valid, 0);
            chk("rsel_after_ready", req_ready, 1);
            edge_t();
        end

        // Normal operation resumes after a mid-flight reset.
        run_req(tbl[0], 1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
